input_channel_sequencer: RTL
============================

# input_channel_sequencer

Synthesizable multi-channel input feeder. It streams a planar multi-channel image out of a single-port synchronous RAM into the per-channel `data_i`/`data_valid_i`/`hold_data_o` handshake of a `winograd_4x4_conv_core`. The block replaces the ad-hoc channel sequencing that currently lives in the system benches. It extends that sequencing with start/done control, end-of-channel detection, a planar (non-interleaved) mode and a configurable per-channel stride.

## Interface
- `ADDR_WIDTH`, 16, RAM address width
- `DATA_WIDTH`, 32, word width (Q-format opaque to this block)
- `N_CHANNELS`, 3, number of input channels
- `N_ROWS`, 28, rows per channel plane
- `N_COLS`, 28, columns per channel plane
- `BASE_ADDR`, 0, RAM address of channel 0 word 0
- `CHANNEL_STRIDE`, `N_ROWS*N_COLS`, address distance between channel planes (must be ≥ `N_ROWS*N_COLS`)
- `INTERLEAVED`, 1, 1: switch channel on consumer hold; 0: planar, hold only stalls

- `clock_i`  in  1  system clock
- `reset_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  begin one frame; sampled only in IDLE
- `ram_data_i`  in  `DATA_WIDTH`  RAM read data, 1-cycle read latency
- `hold_data_i[N_CHANNELS]`  in  1 each  consumer hold per channel
- `ram_rdaddress_o`  out  `ADDR_WIDTH`  RAM read address (combinational)
- `data_o[N_CHANNELS]`  out  `DATA_WIDTH` each  per-channel data register
- `data_valid_o[N_CHANNELS]`  out  1 each  per-channel valid
- `curr_channel_o`  out  `$clog2(N_CHANNELS)+1`  active channel index
- `busy_o`  out  1  high from start acceptance until done
- `done_o`  out  1  one-cycle pulse after last word of last channel consumed

## Operation
- Per-channel state:
  - `rd_ptr[c]`: next address to load, reset to `BASE_ADDR + c*CHANNEL_STRIDE`.
  - `consumed[c]`: count, 0..`N_ROWS*N_COLS`.
  - `loaded[c]`: `data_o[c]` holds an unconsumed word.
  - `exhausted[c]`.
- RAM model: `ram_data_i` in cycle t+1 = mem[`ram_rdaddress_o` in cycle t].
- `ram_rdaddress_o` = `rd_ptr[curr]` plus 1 when a consume occurs this cycle and it is not the channel's last word. This address prefetch guarantees `ram_data_i` = mem[`rd_ptr[curr]`] in every STREAM cycle.
- Consume: occurs at an edge where the state is STREAM, `data_valid_o[curr]`=1 and `hold_data_i[curr]`=0.
  - `consumed[curr]++`.
  - If not the last word: `data_o[curr]` ← `ram_data_i`, `rd_ptr[curr]++`.
  - If the last word: `data_valid_o[curr]` ← 0, `exhausted[curr]` ← 1, `loaded[curr]` ← 0.
- Next channel = lowest-distance round-robin successor of `curr` with `exhausted`=0.
- FSM:
  - IDLE: outputs idle. On `start_i`: clear all `rd_ptr`/`consumed`/`loaded`/`exhausted`, `curr` ← 0, → FETCH.
  - FETCH: one wait cycle. At the edge: `data_o[0]` ← `ram_data_i`, `rd_ptr[0]++`, `loaded[0]`=1, `data_valid_o[0]`=1, → STREAM.
  - STREAM, handled in priority order:
    - Last word consumed: if channels remain, `curr` ← next, → SWITCH; else → DONE.
    - `INTERLEAVED`=1 and `hold_data_i[curr]`=1: `data_valid_o[curr]` ← 0 (`data_o` and `loaded` kept), `curr` ← next (may equal `curr` if it is the only one left), → SWITCH.
    - `INTERLEAVED`=0 and hold: stall, all outputs held.
  - SWITCH: minimum 1 cycle. Wait for `hold_data_i[curr]`=0.
    - Then, if `loaded[curr]`: `data_valid_o[curr]` ← 1.
    - Else: `data_o[curr]` ← `ram_data_i`, `rd_ptr[curr]++`, `loaded`=1, valid ← 1.
    - → STREAM.
  - DONE: `done_o`=1 for one cycle, → IDLE.
- A held word is never discarded or re-read. Data order per channel is strictly ascending addresses.
- At most one `data_valid_o` bit is high in any cycle.
- Reset (any state): all registers return to reset values; an in-flight frame is abandoned.

## Timing
- Reset values:
  - `data_o` = 32'habababab (all channels).
  - `data_valid_o` = 0, `busy_o` = 0, `done_o` = 0, `curr_channel_o` = 0.
  - `ram_rdaddress_o` = `BASE_ADDR`.
  - State = IDLE.
- Start latency: `start_i` at edge E0; `data_valid_o[0]`=1 with mem[`BASE_ADDR`] after E1.
- Sustained throughput: 1 word/cycle per active channel with hold low.
- Channel switch cost: hold edge → new valid ≥ 2 edges.
- `done_o` is asserted the cycle after the edge consuming the final word; `busy_o` falls together with `done_o`.
- `start_i` while `busy_o`=1 is ignored.
- `start_i` in the same cycle as `done_o` is ignored; the block returns to IDLE first.

## Test plan
- Reset check, `N_CHANNELS`=3, `N_ROWS`=`N_COLS`=4, mem[i]=i: assert reset 2 cycles → all outputs at reset values, `ram_rdaddress_o`=0.
- `INTERLEAVED`=1, hold never asserted, pulse start → ch0 emits 0..15 on 16 consecutive cycles, then ch1 emits 16..31, then ch2 emits 32..47. `done_o` pulses exactly once; exactly 48 valid words total.
- `INTERLEAVED`=1, hold ch0 asserted after 4 consumes, ch1 held after 3 → ch1 starts at 16, ch2 starts at 32. The next ch0 valid presents 4 (held word), and no word is lost or duplicated across the full frame.
- `INTERLEAVED`=0, hold ch0 high for 5 cycles mid-plane → `data_o[0]` constant, no channel switch, stream resumes with the next ascending value.
- `reset_i` asserted mid-ch1 → next cycle all outputs at reset values. A new start restreams from address 0.
- Start pulse while busy → ignored. Second start after `done_o` → identical 48-word sequence.

Source files
------------

// File: rtl/input_channel_sequencer.sv
// Multi-channel input feeder: streams planar channel images out of a
// single-port synchronous RAM (1-cycle read latency) into a per-channel
// data/valid/hold consumer. It supports interleaved or planar channel order.
module input_channel_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned N_CHANNELS     = 3,
  parameter int unsigned N_ROWS         = 28,
  parameter int unsigned N_COLS         = 28,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned CHANNEL_STRIDE = N_ROWS * N_COLS,
  parameter int unsigned INTERLEAVED    = 1
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [DATA_WIDTH-1:0]         ram_data_i,
  input  logic [N_CHANNELS-1:0]         hold_data_i,
  output logic [ADDR_WIDTH-1:0]         ram_rdaddress_o,
  output logic [DATA_WIDTH-1:0]         data_o [N_CHANNELS],
  output logic [N_CHANNELS-1:0]         data_valid_o,
  output logic [$clog2(N_CHANNELS):0]   curr_channel_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned PLANE  = N_ROWS * N_COLS;
  localparam int unsigned CNT_W  = $clog2(PLANE + 1);
  localparam int unsigned CURR_W = $clog2(N_CHANNELS) + 1;
  localparam logic [7:0]  AB_BYTE = 8'hab;

  // Builds the idle data pattern (0xab repeated) for any word width.
  function automatic logic [DATA_WIDTH-1:0] fill_ab();
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      w[i] = AB_BYTE[i % 8];
    end
    return w;
  endfunction

  localparam logic [DATA_WIDTH-1:0] RESET_WORD = fill_ab();

  // Address of word 0 of channel c.
  function automatic logic [ADDR_WIDTH-1:0] chan_base(input int unsigned c);
    return ADDR_WIDTH'(BASE_ADDR + c * CHANNEL_STRIDE);
  endfunction

  // Nearest round-robin successor of cur that is not exhausted; MSB = found.
  function automatic logic [CURR_W:0] next_chan(input logic [CURR_W-1:0] cur,
                                                input logic [N_CHANNELS-1:0] exh);
    logic [CURR_W:0] r;
    int unsigned     idx;
    r = {1'b0, cur};
    for (int d = int'(N_CHANNELS); d > 0; d--) begin
      idx = (int'(cur) + d) % N_CHANNELS;
      if (!exh[idx]) r = {1'b1, CURR_W'(idx)};
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM,
    S_SWITCH,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CURR_W-1:0]       curr_q, curr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q [N_CHANNELS];
  logic [ADDR_WIDTH-1:0]   rd_ptr_d [N_CHANNELS];
  logic [CNT_W-1:0]        consumed_q [N_CHANNELS];
  logic [CNT_W-1:0]        consumed_d [N_CHANNELS];
  logic [DATA_WIDTH-1:0]   data_q [N_CHANNELS];
  logic [DATA_WIDTH-1:0]   data_d [N_CHANNELS];
  logic [N_CHANNELS-1:0]   loaded_q, loaded_d;
  logic [N_CHANNELS-1:0]   exhausted_q, exhausted_d;
  logic [N_CHANNELS-1:0]   valid_q, valid_d;
  logic                    busy_q, done_q;
  logic [CURR_W:0]         nxt_c;

  // Next-state logic: channel sequencing, consumption and reload from RAM.
  always_comb begin
    state_d     = state_q;
    curr_d      = curr_q;
    rd_ptr_d    = rd_ptr_q;
    consumed_d  = consumed_q;
    data_d      = data_q;
    loaded_d    = loaded_q;
    exhausted_d = exhausted_q;
    valid_d     = valid_q;
    nxt_c       = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          for (int unsigned c = 0; c < N_CHANNELS; c++) begin
            rd_ptr_d[c]   = chan_base(c);
            consumed_d[c] = '0;
          end
          loaded_d    = '0;
          exhausted_d = '0;
          curr_d      = '0;
          state_d     = S_FETCH;
        end
      end

      S_FETCH: begin
        data_d[0]   = ram_data_i;
        rd_ptr_d[0] = rd_ptr_q[0] + ADDR_WIDTH'(1);
        loaded_d[0] = 1'b1;
        valid_d[0]  = 1'b1;
        state_d     = S_STREAM;
      end

      S_STREAM: begin
        if (!hold_data_i[curr_q]) begin
          consumed_d[curr_q] = consumed_q[curr_q] + CNT_W'(1);
          if (consumed_q[curr_q] == CNT_W'(PLANE - 1)) begin
            valid_d[curr_q]     = 1'b0;
            exhausted_d[curr_q] = 1'b1;
            loaded_d[curr_q]    = 1'b0;
            nxt_c = next_chan(curr_q, exhausted_d);
            if (nxt_c[CURR_W]) begin
              curr_d  = nxt_c[CURR_W-1:0];
              state_d = S_SWITCH;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            data_d[curr_q]   = ram_data_i;
            rd_ptr_d[curr_q] = rd_ptr_q[curr_q] + ADDR_WIDTH'(1);
          end
        end else if (INTERLEAVED != 0) begin
          // Held word stays in data_q and is re-presented on return.
          valid_d[curr_q] = 1'b0;
          nxt_c   = next_chan(curr_q, exhausted_q);
          curr_d  = nxt_c[CURR_W-1:0];
          state_d = S_SWITCH;
        end
      end

      S_SWITCH: begin
        if (!hold_data_i[curr_q]) begin
          if (!loaded_q[curr_q]) begin
            data_d[curr_q]   = ram_data_i;
            rd_ptr_d[curr_q] = rd_ptr_q[curr_q] + ADDR_WIDTH'(1);
            loaded_d[curr_q] = 1'b1;
          end
          valid_d[curr_q] = 1'b1;
          state_d         = S_STREAM;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Prefetch: present the pointer the active channel will hold after this edge.
  always_comb begin
    ram_rdaddress_o = ADDR_WIDTH'(BASE_ADDR);
    if (state_q != S_IDLE) ram_rdaddress_o = rd_ptr_d[curr_d];
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      curr_q      <= '0;
      loaded_q    <= '0;
      exhausted_q <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int unsigned c = 0; c < N_CHANNELS; c++) begin
        rd_ptr_q[c]   <= chan_base(c);
        consumed_q[c] <= '0;
        data_q[c]     <= RESET_WORD;
      end
    end else begin
      state_q     <= state_d;
      curr_q      <= curr_d;
      rd_ptr_q    <= rd_ptr_d;
      consumed_q  <= consumed_d;
      data_q      <= data_d;
      loaded_q    <= loaded_d;
      exhausted_q <= exhausted_d;
      valid_q     <= valid_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign data_o         = data_q;
  assign data_valid_o   = valid_q;
  assign curr_channel_o = curr_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
